// File: rtl/half_adder_pkg.sv
// Shared types and helpers for the half_adder slice: lane result struct and the
// single-lane evaluation function used by half_adder_lane.
package half_adder_pkg;

    localparam int HA_MAX_WIDTH     = 64;
    localparam int HA_DEFAULT_CNT_W = 16;

    typedef struct packed {
        logic s;
        logic c;
    } ha_lane_t;

    // Plain XOR/AND so an X on either input shows up in the result rather than being masked.
    function automatic ha_lane_t ha_eval(input logic a, input logic b);
        ha_lane_t r;
        r.s = a ^ b;
        r.c = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_lane.sv
// One-bit combinational half-adder cell; the top level replicates it once per lane.
module half_adder_lane
    import half_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    ha_lane_t res;

    assign res = ha_eval(a, b);
    assign s   = res.s;
    assign c   = res.c;

endmodule

// File: rtl/half_adder.sv
// Bit-parallel half adder with zero-latency outputs plus a one-cycle registered copy.
// Define HALF_ADDER_STATS_EN to add saturating op_count/carry_count statistics.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = HA_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid
`ifdef HALF_ADDER_STATS_EN
    ,
    output logic [CNT_W-1:0] carry_count,
    output logic [CNT_W-1:0] op_count
`endif
);

    // Lanes are fully independent: no carry is chained between neighbours.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_lane u_lane (
            .a (a[i]),
            .b (b[i]),
            .s (sum[i]),
            .c (carry[i])
        );
    end

    // Data registers hold their contents on idle cycles; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            carry_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q   <= sum;
                carry_q <= carry;
            end
        end
    end

`ifdef HALF_ADDER_STATS_EN
    // Counters stick at all-ones instead of wrapping so long runs stay meaningful.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count    <= '0;
            carry_count <= '0;
        end else if (in_valid) begin
            if (op_count != '1) begin
                op_count <= op_count + CNT_W'(1);
            end
            if ((|carry) && (carry_count != '1)) begin
                carry_count <= carry_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: a WIDTH=1 and a WIDTH=8 instance driven in
// parallel and compared against an arithmetic reference model (a[i]+b[i] per lane).
module tb_half_adder;

    localparam int CW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;

    logic [7:0] sum8, carry8, sum_q8, carry_q8;
    logic       out_valid8;
    logic [0:0] sum1, carry1, sum_q1, carry_q1;
    logic       out_valid1;
`ifdef HALF_ADDER_STATS_EN
    logic [CW-1:0] carry_count8, op_count8, carry_count1, op_count1;
`endif

    int checks = 0;
    int passes = 0;

    // Reference model state for the registered path and statistics.
    logic [7:0] m_sum_q, m_carry_q;
    logic       m_valid;
    int         m_ops, m_carries;

    always #5 clk = ~clk;

    half_adder #(.WIDTH(8), .CNT_W(CW)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .a           (a),
        .b           (b),
        .sum         (sum8),
        .carry       (carry8),
        .sum_q       (sum_q8),
        .carry_q     (carry_q8),
        .out_valid   (out_valid8)
`ifdef HALF_ADDER_STATS_EN
        ,
        .carry_count (carry_count8),
        .op_count    (op_count8)
`endif
    );

    half_adder #(.WIDTH(1), .CNT_W(CW)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .a           (a[0:0]),
        .b           (b[0:0]),
        .sum         (sum1),
        .carry       (carry1),
        .sum_q       (sum_q1),
        .carry_q     (carry_q1),
        .out_valid   (out_valid1)
`ifdef HALF_ADDER_STATS_EN
        ,
        .carry_count (carry_count1),
        .op_count    (op_count1)
`endif
    );

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Each lane is the two-bit number a[i]+b[i]: low bit is sum, high bit is carry.
    function automatic void ref_eval(input logic [7:0] x, input logic [7:0] y,
                                     output logic [7:0] s, output logic [7:0] c);
        for (int i = 0; i < 8; i++) begin
            int t;
            t    = (x[i] ? 1 : 0) + (y[i] ? 1 : 0);
            s[i] = ((t % 2) == 1);
            c[i] = ((t / 2) == 1);
        end
    endfunction

    task automatic check_comb(input string tag);
        logic [7:0] es, ec;
        ref_eval(a, b, es, ec);
        check_output({tag, "_sum8"},   64'(sum8),   64'(es));
        check_output({tag, "_carry8"}, 64'(carry8), 64'(ec));
        check_output({tag, "_sum1"},   64'(sum1),   64'(es[0]));
        check_output({tag, "_carry1"}, 64'(carry1), 64'(ec[0]));
    endtask

    // Called at a negedge: drive inputs, check combinational, advance one edge, check registers.
    task automatic apply_stimulus(input string tag, input logic r, input logic v,
                                  input logic [7:0] aa, input logic [7:0] bb);
        logic [7:0] es, ec;
        rst = r; in_valid = v; a = aa; b = bb;
        #1;
        check_comb(tag);
        ref_eval(aa, bb, es, ec);
        @(posedge clk);
        if (r) begin
            m_sum_q = '0; m_carry_q = '0; m_valid = 1'b0; m_ops = 0; m_carries = 0;
        end else begin
            m_valid = v;
            if (v) begin
                m_sum_q   = es;
                m_carry_q = ec;
                m_ops     = (m_ops < 15) ? m_ops + 1 : 15;
                if (ec != 0) m_carries = (m_carries < 15) ? m_carries + 1 : 15;
            end
        end
        @(negedge clk);
        check_output({tag, "_sum_q8"},   64'(sum_q8),     64'(m_sum_q));
        check_output({tag, "_carry_q8"}, 64'(carry_q8),   64'(m_carry_q));
        check_output({tag, "_valid8"},   64'(out_valid8), 64'(m_valid));
        check_output({tag, "_sum_q1"},   64'(sum_q1),     64'(m_sum_q[0]));
        check_output({tag, "_carry_q1"}, 64'(carry_q1),   64'(m_carry_q[0]));
        check_output({tag, "_valid1"},   64'(out_valid1), 64'(m_valid));
`ifdef HALF_ADDER_STATS_EN
        check_output({tag, "_ops8"},     64'(op_count8),    64'(m_ops));
        check_output({tag, "_carries8"}, 64'(carry_count8), 64'(m_carries));
        check_output({tag, "_ops1"},     64'(op_count1),    64'(m_ops));
        check_output({tag, "_carries1"}, 64'(carry_count1), 64'(m_carries));
`endif
    endtask

    initial begin
        m_sum_q = '0; m_carry_q = '0; m_valid = 1'b0; m_ops = 0; m_carries = 0;

        // Combinational sweep while held in reset: outputs must stay live.
        rst = 1'b1; in_valid = 1'b0;
        a = 8'h00; b = 8'h00; #4; check_comb("sweep00");
        #1; a = 8'h00; b = 8'h01; #4; check_comb("sweep01");
        #3; a = 8'h01; b = 8'h00; #3; check_comb("sweep10");
        #1; a = 8'h01; b = 8'h01; #3; check_comb("sweep11");
        @(negedge clk);

        apply_stimulus("init_rst", 1'b1, 1'b0, 8'h00, 8'h00);
        apply_stimulus("load11",   1'b0, 1'b1, 8'hFF, 8'hFF);
        apply_stimulus("hold",     1'b0, 1'b0, 8'h00, 8'h00);
        apply_stimulus("rst_prio", 1'b1, 1'b1, 8'hFF, 8'hFF);
        apply_stimulus("lanes",    1'b0, 1'b1, 8'hF0, 8'hCC);
        apply_stimulus("allones",  1'b0, 1'b1, 8'hFF, 8'hFF);

        // Saturation run then clear.
        apply_stimulus("sat_rst", 1'b1, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 20; i++) apply_stimulus("sat", 1'b0, 1'b1, 8'h01, 8'h01);
        apply_stimulus("sat_clr", 1'b1, 1'b0, 8'h00, 8'h00);

        // Mixed ops: 00, 01, 11, idle -> 3 ops, 1 with carry.
        apply_stimulus("mix00",   1'b0, 1'b1, 8'h00, 8'h00);
        apply_stimulus("mix01",   1'b0, 1'b1, 8'h00, 8'h01);
        apply_stimulus("mix11",   1'b0, 1'b1, 8'h01, 8'h01);
        apply_stimulus("mixidle", 1'b0, 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 60; i++) begin
            apply_stimulus("rand", ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                           8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
